// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel/line coordinates and timing lock from raw VGA sync pins.
//
// Ports:
//   clk       system clock; one sync sample per rising edge
//   reset     asynchronous, active-low reset
//   hsync     horizontal sync pin, active-low pulse, asynchronous to clk
//   vsync     vertical sync pin, active-low pulse, asynchronous to clk
//   x, y      recovered pixel column / line, 0 outside the visible window
//   video_on  locked and inside the visible window
//   h_total   last measured line period in clocks
//   v_total   last measured frame length in lines
//   locked    timing has been stable for LOCK_FRAMES consecutive frames
//   err       one-cycle pulse when lock is lost
module vga_sync_decoder #(
  parameter int unsigned H_OFFSET    = 144,
  parameter int unsigned V_OFFSET    = 35,
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        video_on,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        locked,
  output logic        err
);

  localparam logic [10:0] CntMax = 11'h7ff;
  localparam int unsigned MatchW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [MatchW-1:0] MatchLock = MatchW'(LOCK_FRAMES);
  localparam logic [11:0] HStart = 12'(H_OFFSET);
  localparam logic [11:0] HEnd   = 12'(H_OFFSET + H_VISIBLE);
  localparam logic [11:0] VStart = 12'(V_OFFSET);
  localparam logic [11:0] VEnd   = 12'(V_OFFSET + V_VISIBLE);
  localparam logic [10:0] HOff   = 11'(H_OFFSET);
  localparam logic [10:0] VOff   = 11'(V_OFFSET);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  // [0],[1] synchronizer, [2] edge register
  logic [2:0] hs_q, vs_q;
  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [10:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [10:0] h_ref_q, h_ref_d, v_ref_q, v_ref_d;
  logic        h_ref_valid_q, h_ref_valid_d, v_ref_valid_q, v_ref_valid_d;
  logic        frame_bad_q, frame_bad_d;
  logic [MatchW-1:0] match_q, match_d;
  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        video_q, video_d, locked_q, locked_d, err_q, err_d;

  logic        hfall, vfall, sync_loss, h_mismatch, frame_good, in_h, in_v;
  logic [10:0] h_meas, v_meas;

  // Counters, measurements and per-frame line-length check
  always_comb begin
    hfall = hs_q[2] & ~hs_q[1];
    vfall = vs_q[2] & ~vs_q[1];

    h_meas = (hcount_q == CntMax) ? CntMax : hcount_q + 11'd1;
    v_meas = (vcount_q == CntMax) ? CntMax : vcount_q + 11'd1;

    hcount_d  = hfall ? 11'd0 : h_meas;
    vcount_d  = vfall ? 11'd0 : (hfall ? v_meas : vcount_q);
    h_total_d = hfall ? h_meas : h_total_q;
    v_total_d = vfall ? v_meas : v_total_q;

    // Fires once, on the cycle hcount climbs onto the saturation value
    sync_loss = !hfall && (hcount_q == CntMax - 11'd1);

    // A line ending on the same edge as vfall still belongs to the ending frame
    h_mismatch = hfall && (h_meas != h_ref_q);
    frame_good = !frame_bad_q && !(h_mismatch && h_ref_valid_q);

    h_ref_d       = h_ref_q;
    h_ref_valid_d = h_ref_valid_q;
    frame_bad_d   = frame_bad_q;
    if (vfall) begin
      h_ref_valid_d = 1'b0;
      frame_bad_d   = 1'b0;
    end else if (hfall) begin
      if (!h_ref_valid_q) begin
        h_ref_d       = h_meas;
        h_ref_valid_d = 1'b1;
      end else if (h_mismatch) begin
        frame_bad_d = 1'b1;
      end
    end
  end

  // Lock FSM next state
  always_comb begin
    state_d       = state_q;
    match_d       = match_q;
    v_ref_d       = v_ref_q;
    v_ref_valid_d = v_ref_valid_q;
    err_d         = 1'b0;

    if (sync_loss) begin
      state_d       = StSearch;
      match_d       = '0;
      v_ref_valid_d = 1'b0;
      err_d         = (state_q == StLocked);
    end else begin
      case (state_q)
        StSearch: begin
          if (vfall) begin
            state_d       = StAcquire;
            match_d       = '0;
            v_ref_valid_d = 1'b0;
          end
        end
        StAcquire: begin
          if (vfall) begin
            if (frame_good && v_ref_valid_q && (v_meas == v_ref_q)) begin
              match_d = match_q + MatchW'(1);
            end else begin
              match_d = '0;
            end
            v_ref_d       = v_meas;
            v_ref_valid_d = 1'b1;
            if (match_d == MatchLock) state_d = StLocked;
          end
        end
        StLocked: begin
          // h_ref_q still holds the previous frame's reference on a frame's first line
          if (h_mismatch || (vfall && (v_meas != v_ref_q))) begin
            err_d   = 1'b1;
            state_d = StAcquire;
            match_d = '0;
          end
          if (vfall) begin
            v_ref_d       = v_meas;
            v_ref_valid_d = 1'b1;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Registered outputs, aligned with the counters they are derived from
  always_comb begin
    locked_d = (state_d == StLocked);
    in_h     = ({1'b0, hcount_d} >= HStart) && ({1'b0, hcount_d} < HEnd);
    in_v     = ({1'b0, vcount_d} >= VStart) && ({1'b0, vcount_d} < VEnd);
    video_d  = locked_d && in_h && in_v;
    x_d      = video_d ? hcount_d - HOff : 11'd0;
    y_d      = video_d ? vcount_d - VOff : 11'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q          <= 3'b111;
      vs_q          <= 3'b111;
      hcount_q      <= '0;
      vcount_q      <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      h_ref_q       <= '0;
      h_ref_valid_q <= 1'b0;
      frame_bad_q   <= 1'b0;
      v_ref_q       <= '0;
      v_ref_valid_q <= 1'b0;
      match_q       <= '0;
      state_q       <= StSearch;
      x_q           <= '0;
      y_q           <= '0;
      video_q       <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hs_q          <= {hs_q[1:0], hsync};
      vs_q          <= {vs_q[1:0], vsync};
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      h_ref_q       <= h_ref_d;
      h_ref_valid_q <= h_ref_valid_d;
      frame_bad_q   <= frame_bad_d;
      v_ref_q       <= v_ref_d;
      v_ref_valid_q <= v_ref_valid_d;
      match_q       <= match_d;
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_q       <= video_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign video_on = video_q;
  assign h_total  = h_total_q;
  assign v_total  = v_total_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed testbench for vga_sync_decoder. Horizontal timing is the real 800-clock line;
// frames are shortened to 5 lines (visible lines 2..3) so lock sequences stay short.
module tb_vga_sync_decoder;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync;
  logic [10:0] x, y, h_total, v_total;
  logic        video_on, locked, err;

  int errors = 0;
  int checks = 0;

  // Sync generator state; lag_* is the pin position the DUT counters currently reflect
  int hpos = 0, vpos = 0, hlen = 800, hlow = 96, vlines = 5, vlow = 2, long_line = -1;
  bit gen_on = 1'b0;
  int p1_h = -1, p1_v = -1, p2_h = -1, p2_v = -1, lag_h = -1, lag_v = -1;
  int err_cnt = 0;

  vga_sync_decoder #(
    .H_OFFSET   (144),
    .V_OFFSET   (2),
    .H_VISIBLE  (640),
    .V_VISIBLE  (2),
    .LOCK_FRAMES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .hsync   (hsync),
    .vsync   (vsync),
    .x       (x),
    .y       (y),
    .video_on(video_on),
    .h_total (h_total),
    .v_total (v_total),
    .locked  (locked),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic gen_cycle();
    int cur_h, cur_v, len;
    if (gen_on) begin
      hsync = (hpos >= hlow);
      vsync = (vpos >= vlow);
      cur_h = hpos;
      cur_v = vpos;
    end else begin
      hsync = 1'b1;
      vsync = 1'b1;
      cur_h = -1;
      cur_v = -1;
    end
    // Counters follow the pins with two cycles of synchronizer delay
    lag_h = p2_h; lag_v = p2_v;
    p2_h  = p1_h; p2_v  = p1_v;
    p1_h  = cur_h; p1_v = cur_v;
    @(posedge clk);
    #1;
    if (err === 1'b1) err_cnt++;
    if (gen_on) begin
      len = hlen + ((vpos == long_line) ? 1 : 0);
      hpos++;
      if (hpos >= len) begin
        hpos = 0;
        if (vpos == long_line) long_line = -1;
        vpos++;
        if (vpos >= vlines) vpos = 0;
      end
    end
  endtask

  task automatic run_to(input int v, input int h, input string name);
    int n = 0;
    do begin
      gen_cycle();
      n++;
    end while (!(lag_v == v && lag_h == h) && n < 20000);
    if (!(lag_v == v && lag_h == h)) begin
      checks++; errors++;
      $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", name, v, h, lag_v, lag_h);
    end
  endtask

  task automatic start_gen(input int hl, input int hw, input int vl, input int vw);
    hlen = hl; hlow = hw; vlines = vl; vlow = vw;
    hpos = 0; vpos = 0; long_line = -1; gen_on = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; hsync = 1'b1; vsync = 1'b1; gen_on = 1'b0;
    repeat (2) gen_cycle();
    checks++;
    if ({x, y, video_on} !== 23'd0) begin
      errors++; $display("FAIL reset_coords: x=%0d y=%0d video_on=%b, want 0", x, y, video_on);
    end
    checks++;
    if ({h_total, v_total} !== 22'd0) begin
      errors++; $display("FAIL reset_totals: h_total=%0d v_total=%0d, want 0", h_total, v_total);
    end
    checks++;
    if ({locked, err} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: locked=%b err=%b, want 0", locked, err);
    end
    reset = 1'b1;
    err_cnt = 0;
    repeat (10) gen_cycle();
    checks++;
    if (err_cnt !== 0) begin
      errors++; $display("FAIL reset_release_err: err cycles=%0d, want 0", err_cnt);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL reset_release_locked: locked=%b, want 0", locked);
    end
  endtask

  task automatic test_lock();
    start_gen(800, 96, 5, 2);
    run_to(0, 0, "vfall1");
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_vfall1: locked=%b want 0", locked); end
    run_to(0, 0, "vfall2");
    checks++;
    if (h_total !== 11'd800) begin
      errors++; $display("FAIL lock_h_total: h_total=%0d want 800", h_total);
    end
    checks++;
    if (v_total !== 11'd5) begin
      errors++; $display("FAIL lock_v_total: v_total=%0d want 5", v_total);
    end
    run_to(0, 0, "vfall3");
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_vfall3: locked=%b want 0", locked); end
    run_to(4, 799, "pre_vfall4");
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_pre4: locked=%b want 0", locked); end
    run_to(0, 0, "vfall4");
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_vfall4: locked=%b want 1", locked); end
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL lock_no_err: err cycles=%0d want 0", err_cnt); end
  endtask

  task automatic test_window();
    run_to(1, 144, "line1");
    checks++;
    if (video_on !== 1'b0) begin errors++; $display("FAIL win_line1: video_on=%b want 0", video_on); end
    run_to(2, 143, "h143");
    checks++;
    if ({video_on, x} !== 12'd0) begin
      errors++; $display("FAIL win_h143: video_on=%b x=%0d want 0/0", video_on, x);
    end
    run_to(2, 144, "h144");
    checks++;
    if (video_on !== 1'b1 || x !== 11'd0 || y !== 11'd0) begin
      errors++; $display("FAIL win_first: video_on=%b x=%0d y=%0d want 1/0/0", video_on, x, y);
    end
    run_to(2, 783, "h783");
    checks++;
    if (video_on !== 1'b1 || x !== 11'd639) begin
      errors++; $display("FAIL win_last_col: video_on=%b x=%0d want 1/639", video_on, x);
    end
    run_to(2, 784, "h784");
    checks++;
    if ({video_on, x, y} !== 23'd0) begin
      errors++; $display("FAIL win_h784: video_on=%b x=%0d y=%0d want 0", video_on, x, y);
    end
    run_to(3, 200, "mid");
    checks++;
    if (video_on !== 1'b1 || x !== 11'd56 || y !== 11'd1) begin
      errors++; $display("FAIL win_mid: video_on=%b x=%0d y=%0d want 1/56/1", video_on, x, y);
    end
    run_to(4, 144, "below");
    checks++;
    if ({video_on, y} !== 12'd0) begin
      errors++; $display("FAIL win_below: video_on=%b y=%0d want 0/0", video_on, y);
    end
  endtask

  task automatic test_long_line();
    int base;
    run_to(0, 0, "vfall5");
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL long_prelock: locked=%b want 1", locked); end
    long_line = 3;
    base = err_cnt;
    run_to(3, 800, "long_tail");
    checks++;
    if (locked !== 1'b1 || err_cnt !== base) begin
      errors++; $display("FAIL long_before: locked=%b err cycles=%0d want 1/0", locked, err_cnt - base);
    end
    run_to(4, 0, "long_end");
    checks++;
    if (err !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL long_err: err=%b locked=%b want 1/0", err, locked);
    end
    checks++;
    if (h_total !== 11'd801) begin
      errors++; $display("FAIL long_h_total: h_total=%0d want 801", h_total);
    end
    gen_cycle();
    checks++;
    if (err !== 1'b0 || err_cnt - base !== 1) begin
      errors++; $display("FAIL long_err_width: err=%b cycles=%0d want 0/1", err, err_cnt - base);
    end
    for (int i = 1; i <= 3; i++) begin
      run_to(0, 0, "relock");
      checks++;
      if (locked !== (i == 3)) begin
        errors++; $display("FAIL relock_%0d: locked=%b want %b", i, locked, (i == 3));
      end
    end
  endtask

  task automatic test_sync_loss();
    int base;
    run_to(1, 300, "hold_start");
    base = err_cnt;
    gen_on = 1'b0;
    repeat (2000) gen_cycle();
    checks++;
    if (err_cnt - base !== 1) begin
      errors++; $display("FAIL loss_err: err cycles=%0d want 1", err_cnt - base);
    end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked: locked=%b want 0", locked); end
    checks++;
    if ({video_on, x, y} !== 23'd0) begin
      errors++; $display("FAIL loss_coords: video_on=%b x=%0d y=%0d want 0", video_on, x, y);
    end
    checks++;
    if (h_total !== 11'd800) begin
      errors++; $display("FAIL loss_h_total: h_total=%0d want 800", h_total);
    end
  endtask

  task automatic test_coincident_restart();
    start_gen(800, 96, 5, 2);
    for (int i = 1; i <= 4; i++) begin
      run_to(0, 0, "restart");
      checks++;
      if (locked !== (i == 4)) begin
        errors++; $display("FAIL restart_vfall%0d: locked=%b want %b", i, locked, (i == 4));
      end
    end
    run_to(2, 144, "restart_origin");
    checks++;
    if (video_on !== 1'b1 || x !== 11'd0 || y !== 11'd0) begin
      errors++; $display("FAIL restart_origin: video_on=%b x=%0d y=%0d want 1/0/0", video_on, x, y);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    run_to(3, 400, "pre_reset");
    checks++;
    if (video_on !== 1'b1 || x !== 11'd256 || y !== 11'd1) begin
      errors++; $display("FAIL mid_pre: video_on=%b x=%0d y=%0d want 1/256/1", video_on, x, y);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({locked, video_on, x, y} !== 24'd0) begin
      errors++; $display("FAIL mid_reset: locked=%b video_on=%b x=%0d y=%0d want 0", locked,
                         video_on, x, y);
    end
    checks++;
    if ({h_total, v_total} !== 22'd0) begin
      errors++; $display("FAIL mid_reset_totals: h=%0d v=%0d want 0", h_total, v_total);
    end
    gen_on = 1'b0;
    repeat (2) gen_cycle();
    reset = 1'b1;
    base = err_cnt;
    repeat (5) gen_cycle();
    checks++;
    if (err_cnt !== base) begin
      errors++; $display("FAIL mid_release_err: err cycles=%0d want 0", err_cnt - base);
    end
  endtask

  task automatic test_tall_frame();
    start_gen(24, 4, 525, 2);
    run_to(0, 0, "tall_vfall1");
    run_to(0, 0, "tall_vfall2");
    checks++;
    if (v_total !== 11'd525) begin
      errors++; $display("FAIL tall_v_total: v_total=%0d want 525", v_total);
    end
    checks++;
    if (h_total !== 11'd24) begin
      errors++; $display("FAIL tall_h_total: h_total=%0d want 24", h_total);
    end
    // Only two vfalls since reset: lock must not have come back
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL tall_locked: locked=%b want 0", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_window();
    test_long_line();
    test_sync_loss();
    test_coincident_restart();
    test_reset_mid_frame();
    test_tall_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_OFFSET, 144, hsync-fall-to-first-visible-pixel distance in clocks.
REQ-002 Parameter V_OFFSET, 35, vsync-fall-to-first-visible-line distance in lines.
REQ-003 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-004 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-005 Parameter LOCK_FRAMES, 2, consecutive matching frames required to lock.
REQ-006 clk  input  1  single system clock; one sync sample per rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 hsync  input  1  horizontal sync, active-low pulse, asynchronous to clk.
REQ-009 vsync  input  1  vertical sync, active-low pulse, asynchronous to clk.
REQ-010 x  output  11  recovered pixel column; 0 when video_on=0.
REQ-011 y  output  11  recovered line; 0 when video_on=0.
REQ-012 video_on  output  1  locked and inside visible window.
REQ-013 h_total  output  11  last measured line period in clocks.
REQ-014 v_total  output  11  last measured frame length in lines.
REQ-015 locked  output  1  timing stable per REQ-024.
REQ-016 err  output  1  one-cycle pulse on loss of lock.

Function
REQ-017 hsync/vsync SHALL pass through a 2-flop synchronizer plus edge register; internal falling-edge strobe (hfall/vfall) SHALL be asserted 3 clk after the pin falls.
REQ-018 hcount (11 bit) SHALL load 0 on hfall, else increment, saturating at 2047.
REQ-019 vcount (11 bit) SHALL load 0 on vfall, increment on hfall otherwise, saturating at 2047; vfall has priority on coincident edges.
REQ-020 On hfall, h_total SHALL load hcount+1 (saturating 2047); on vfall, v_total SHALL load vcount+1 (saturating 2047).
REQ-021 Per-frame line check: the first h_total latched after vfall is the frame reference; any later h_total in the same frame differing from it marks the frame bad.
REQ-022 FSM states SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-023 SEARCH -> ACQUIRE on first vfall; clears match count and v_ref_valid.
REQ-024 ACQUIRE, on each vfall: if frame good and v_ref_valid and v_total==v_ref, match count +1, else match count 0; v_ref <= v_total, v_ref_valid <= 1; when match count reaches LOCK_FRAMES -> LOCKED.
REQ-025 LOCKED: a mismatching h_total (vs. last frame reference) or a v_total != v_ref SHALL pulse err one cycle and go to ACQUIRE with match count 0.
REQ-026 Any state: hcount reaching 2047 (sync loss) SHALL go to SEARCH; err pulses one cycle if leaving LOCKED.
REQ-027 locked = (state==LOCKED), registered, asserted the cycle after the qualifying vfall.
REQ-028 video_on = locked and H_OFFSET <= hcount < H_OFFSET+H_VISIBLE and V_OFFSET <= vcount < V_OFFSET+V_VISIBLE; x = hcount-H_OFFSET, y = vcount-V_OFFSET when video_on; all registered, same cycle alignment as hcount/vcount.
REQ-029 All arithmetic unsigned 11 bit; no wrap-around, only saturation.

Reset
REQ-030 reset low SHALL immediately clear x, y, video_on, h_total, v_total, locked, err, counters, match count, v_ref_valid and synchronizers (sync flops preset to 1, idle), state SEARCH.
REQ-031 Reset mid-frame SHALL discard all measurements; relock requires a full REQ-023/024 sequence.

Verification
REQ-032 Reset asserted -> all outputs 0, locked=0 within same cycle, no err after release with idle syncs.
REQ-033 800 clk/line, 525 lines/frame, hsync 96 low, vsync 2 lines low -> h_total=800, v_total=525; locked rises 1 cycle after 4th detected vfall.
REQ-034 Locked, line 35 -> hcount=144 gives x=0,y=0,video_on=1; hcount=783 gives x=639; hcount=784 gives video_on=0; line 515 gives video_on=0.
REQ-035 Locked, inject one 801-clock line -> err one cycle at next hfall, locked=0, relock after 3 further clean vfalls.
REQ-036 Locked, hold hsync high -> hcount saturates 2047, err one cycle, state SEARCH, x/y hold 0.
REQ-037 Coincident hsync/vsync falls -> vcount=0, hcount=0; reset pulse mid-frame while locked -> locked=0 immediately.
